// File: rtl/pq_host_driver.sv
// pq_host_driver
//   Host-side initiator for the priority-queue interface. Takes one command at
//   a time from a valid/ready stream, checks the device's full/empty/busy
//   state, issues a single-cycle enq/deq pulse (REPL pulses both) and returns
//   one result per command on a second valid/ready stream.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   cmd_valid/ready     command handshake; cmd_op 00 NOP 01 ENQ 10 DEQ 11 REPL
//   cmd_kv              key/value for ENQ/REPL, key in MSBs
//   pq_enq/deq/kvi      registered drive towards the device
//   pq_kvo/full/empty/busy  device head and status
//   rsp_valid/ready     result handshake
//   rsp_kv              head sampled for DEQ/REPL, else 0
//   rsp_status          00 OK, 01 REJ_FULL, 10 REJ_EMPTY, 11 NOP_DONE
//   occupancy           entries believed to be in the device (saturating)
//   order_err           sticky ordering violation
//
// Optional feature: define PQ_HOST_ORDER_CHECK_EN to build the DEQ ordering
// checker. Without it order_err is tied to 0.
module pq_host_driver #(
  parameter int KEY_W     = 16,
  parameter int VAL_W     = 16,
  parameter int CAPACITY  = 15,
  parameter int MIN_GAP   = 2,
  parameter int MIN_FIRST = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [1:0]                    cmd_op,
  input  logic [KEY_W+VAL_W-1:0]        cmd_kv,
  output logic                          pq_enq,
  output logic                          pq_deq,
  output logic [KEY_W+VAL_W-1:0]        pq_kvi,
  input  logic [KEY_W+VAL_W-1:0]        pq_kvo,
  input  logic                          pq_full,
  input  logic                          pq_empty,
  input  logic                          pq_busy,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [KEY_W+VAL_W-1:0]        rsp_kv,
  output logic [1:0]                    rsp_status,
  output logic [$clog2(CAPACITY+1)-1:0] occupancy,
  output logic                          order_err
);

  localparam int KV_W  = KEY_W + VAL_W;
  localparam int OCC_W = $clog2(CAPACITY + 1);
  localparam int GAP_W = (MIN_GAP > 2) ? $clog2(MIN_GAP) : 1;

  localparam logic [GAP_W-1:0] GAP_LOAD = (MIN_GAP > 1) ? GAP_W'(MIN_GAP - 1) : '0;
  localparam logic [OCC_W-1:0] OCC_MAX  = OCC_W'(CAPACITY);

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_ENQ  = 2'b01;
  localparam logic [1:0] OP_DEQ  = 2'b10;
  localparam logic [1:0] OP_REPL = 2'b11;

  localparam logic [1:0] ST_OK        = 2'b00;
  localparam logic [1:0] ST_REJ_FULL  = 2'b01;
  localparam logic [1:0] ST_REJ_EMPTY = 2'b10;
  localparam logic [1:0] ST_NOP_DONE  = 2'b11;

  typedef enum logic [1:0] {IDLE, CHECK, ISSUE, RESP} state_t;

  state_t            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [KV_W-1:0]   kv_q, kv_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              pq_enq_q, pq_enq_d;
  logic              pq_deq_q, pq_deq_d;
  logic [KV_W-1:0]   pq_kvi_q, pq_kvi_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [KV_W-1:0]   rsp_kv_q, rsp_kv_d;
  logic [1:0]        rsp_status_q, rsp_status_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic [GAP_W-1:0]  gap_q, gap_d;

  // Next-state logic. The enq/deq/kvi drive is computed on the way into
  // ISSUE so the registered pulse lines up exactly with the ISSUE cycle.
  // Handshake outputs are derived from the next state so they are registered
  // yet consistent with the state they describe.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    kv_d         = kv_q;
    pq_enq_d     = 1'b0;
    pq_deq_d     = 1'b0;
    pq_kvi_d     = '0;
    rsp_kv_d     = rsp_kv_q;
    rsp_status_d = rsp_status_q;
    occ_d        = occ_q;
    // The gap counter free-runs down to zero regardless of FSM state.
    gap_d        = (gap_q != '0) ? gap_q - 1'b1 : '0;

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          op_d    = cmd_op;
          kv_d    = cmd_kv;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (!pq_busy && (gap_q == '0)) begin
          // With full and empty both set, each op is judged only against the
          // flag that matters to it.
          if (op_q == OP_NOP) begin
            state_d      = RESP;
            rsp_status_d = ST_NOP_DONE;
            rsp_kv_d     = '0;
          end else if ((op_q == OP_ENQ) && pq_full) begin
            state_d      = RESP;
            rsp_status_d = ST_REJ_FULL;
            rsp_kv_d     = '0;
          end else if ((op_q != OP_ENQ) && pq_empty) begin
            state_d      = RESP;
            rsp_status_d = ST_REJ_EMPTY;
            rsp_kv_d     = '0;
          end else begin
            state_d  = ISSUE;
            pq_enq_d = (op_q == OP_ENQ) || (op_q == OP_REPL);
            pq_deq_d = (op_q == OP_DEQ) || (op_q == OP_REPL);
            pq_kvi_d = (op_q == OP_DEQ) ? '0 : kv_q;
          end
        end
      end
      ISSUE: begin
        // pq_kvo here is still the head before the device removes it.
        rsp_kv_d     = (op_q == OP_ENQ) ? '0 : pq_kvo;
        rsp_status_d = ST_OK;
        gap_d        = GAP_LOAD;
        state_d      = RESP;
        if (op_q == OP_ENQ) begin
          occ_d = (occ_q == OCC_MAX) ? occ_q : occ_q + 1'b1;
        end else if (op_q == OP_DEQ) begin
          occ_d = (occ_q == '0) ? occ_q : occ_q - 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    cmd_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
  end

  // All FSM state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      op_q         <= OP_NOP;
      kv_q         <= '0;
      cmd_ready_q  <= 1'b0;
      pq_enq_q     <= 1'b0;
      pq_deq_q     <= 1'b0;
      pq_kvi_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_kv_q     <= '0;
      rsp_status_q <= 2'b00;
      occ_q        <= '0;
      gap_q        <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      kv_q         <= kv_d;
      cmd_ready_q  <= cmd_ready_d;
      pq_enq_q     <= pq_enq_d;
      pq_deq_q     <= pq_deq_d;
      pq_kvi_q     <= pq_kvi_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_kv_q     <= rsp_kv_d;
      rsp_status_q <= rsp_status_d;
      occ_q        <= occ_d;
      gap_q        <= gap_d;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign pq_enq     = pq_enq_q;
  assign pq_deq     = pq_deq_q;
  assign pq_kvi     = pq_kvi_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_kv     = rsp_kv_q;
  assign rsp_status = rsp_status_q;
  assign occupancy  = occ_q;

`ifdef PQ_HOST_ORDER_CHECK_EN
  logic [KEY_W-1:0] last_key_q, last_key_d;
  logic             last_valid_q, last_valid_d;
  logic             order_err_q, order_err_d;
  logic [KEY_W-1:0] new_key;

  assign new_key = pq_kvo[KV_W-1:VAL_W];

  // Ordering checker. last_valid is only ever set by a DEQ and cleared by any
  // ENQ/REPL, so it being set means a run of consecutive DEQs is in progress.
  // A min-first device must hand out non-decreasing keys and a max-first
  // device non-increasing keys; anything else is a violation.
  always_comb begin
    last_key_d   = last_key_q;
    last_valid_d = last_valid_q;
    order_err_d  = order_err_q;
    if (state_q == ISSUE) begin
      if (op_q == OP_DEQ) begin
        if (last_valid_q) begin
          if ((MIN_FIRST != 0) ? (new_key < last_key_q) : (new_key > last_key_q)) begin
            order_err_d = 1'b1;
          end
        end
        last_key_d   = new_key;
        last_valid_d = 1'b1;
      end else begin
        last_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_key_q   <= '0;
      last_valid_q <= 1'b0;
      order_err_q  <= 1'b0;
    end else begin
      last_key_q   <= last_key_d;
      last_valid_q <= last_valid_d;
      order_err_q  <= order_err_d;
    end
  end

  assign order_err = order_err_q;
`else
  assign order_err = 1'b0;
`endif

endmodule

// File: tb/tb_pq_host_driver.sv
// tb_pq_host_driver
//   Directed self-checking bench for pq_host_driver. The bench plays the role
//   of both the command source and the pq device, driving full/empty/busy and
//   the head value by hand. Inputs change on falling edges; outputs are
//   sampled on falling edges.
module tb_pq_host_driver;

  localparam int KV_W  = 32;
  localparam int OCC_W = 4;

  logic             clk;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [KV_W-1:0]  cmd_kv;
  logic             pq_enq;
  logic             pq_deq;
  logic [KV_W-1:0]  pq_kvi;
  logic [KV_W-1:0]  pq_kvo;
  logic             pq_full;
  logic             pq_empty;
  logic             pq_busy;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [KV_W-1:0]  rsp_kv;
  logic [1:0]       rsp_status;
  logic [OCC_W-1:0] occupancy;
  logic             order_err;

  int tests_run;
  int tests_failed;

  int lat, pulse_lat, n_enq, n_deq, n_both;
  logic [KV_W-1:0] kvi_seen;
  int total_pulses, seen_rsp, seen_pulse;
  logic exp_order_err;

  pq_host_driver dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_kv     (cmd_kv),
    .pq_enq     (pq_enq),
    .pq_deq     (pq_deq),
    .pq_kvi     (pq_kvi),
    .pq_kvo     (pq_kvo),
    .pq_full    (pq_full),
    .pq_empty   (pq_empty),
    .pq_busy    (pq_busy),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_kv     (rsp_kv),
    .rsp_status (rsp_status),
    .occupancy  (occupancy),
    .order_err  (order_err)
  );

  // 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it, and on mismatch counts a failure and reports.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Presents one command, waits (bounded) for acceptance, then watches each
  // falling edge until rsp_valid. lat/pulse_lat count falling edges after the
  // accepting rising edge (1 = the cycle right after accept); -1 if never seen.
  // Returns positioned on the falling edge where rsp_valid was first seen.
  task automatic applyStimulus(input logic [1:0] op, input logic [KV_W-1:0] kv,
                               output int o_lat, output int o_pulse_lat,
                               output int o_enq, output int o_deq, output int o_both,
                               output logic [KV_W-1:0] o_kvi);
    int wait_cnt;
    o_lat = -1; o_pulse_lat = -1; o_enq = 0; o_deq = 0; o_both = 0; o_kvi = '0;
    cmd_op = op;
    cmd_kv = kv;
    cmd_valid = 1'b1;
    wait_cnt = 0;
    while (!cmd_ready && wait_cnt < 40) begin
      @(negedge clk);
      wait_cnt++;
    end
    if (!cmd_ready) begin
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op = 2'b00;
    cmd_kv = '0;
    for (int c = 1; c <= 40; c++) begin
      if (pq_enq) o_enq++;
      if (pq_deq) o_deq++;
      if (pq_enq && pq_deq) o_both++;
      if (pq_enq || pq_deq) begin
        o_kvi = pq_kvi;
        o_pulse_lat = c;
      end
      if (rsp_valid) begin
        o_lat = c;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = 2'b00;
    cmd_kv = '0;
    pq_kvo = '0;
    pq_full = 1'b0;
    pq_empty = 1'b0;
    pq_busy = 1'b0;
    rsp_ready = 1'b1;
`ifdef PQ_HOST_ORDER_CHECK_EN
    exp_order_err = 1'b1;
`else
    exp_order_err = 1'b0;
`endif

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("rst_pulses", 64'({pq_enq, pq_deq}), 64'd0);
    checkOutput("rst_occupancy", 64'(occupancy), 64'd0);
    checkOutput("rst_order_err", 64'(order_err), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle_cmd_ready", 64'(cmd_ready), 64'd1);

    // ENQ 0x0005_00AA
    applyStimulus(2'b01, 32'h0005_00AA, lat, pulse_lat, n_enq, n_deq, n_both, kvi_seen);
    checkOutput("enq_latency", 64'(lat), 64'd3);
    checkOutput("enq_pulse_lat", 64'(pulse_lat), 64'd2);
    checkOutput("enq_pulse_count", 64'(n_enq), 64'd1);
    checkOutput("enq_no_deq", 64'(n_deq), 64'd0);
    checkOutput("enq_kvi", 64'(kvi_seen), 64'h0005_00AA);
    checkOutput("enq_status", 64'(rsp_status), 64'd0);
    checkOutput("enq_rsp_kv", 64'(rsp_kv), 64'd0);
    checkOutput("enq_occ", 64'(occupancy), 64'd1);

    // DEQ of that entry: head captured, kvi driven 0
    pq_kvo = 32'h0005_00AA;
    applyStimulus(2'b10, 32'hDEAD_BEEF, lat, pulse_lat, n_enq, n_deq, n_both, kvi_seen);
    checkOutput("deq_latency", 64'(lat), 64'd3);
    checkOutput("deq_pulse_count", 64'(n_deq), 64'd1);
    checkOutput("deq_no_enq", 64'(n_enq), 64'd0);
    checkOutput("deq_kvi_zero", 64'(kvi_seen), 64'd0);
    checkOutput("deq_rsp_kv", 64'(rsp_kv), 64'h0005_00AA);
    checkOutput("deq_occ", 64'(occupancy), 64'd0);

    // DEQ while device empty: rejected
    pq_empty = 1'b1;
    applyStimulus(2'b10, 32'h0, lat, pulse_lat, n_enq, n_deq, n_both, kvi_seen);
    checkOutput("deqe_latency", 64'(lat), 64'd2);
    checkOutput("deqe_no_pulse", 64'(n_enq + n_deq), 64'd0);
    checkOutput("deqe_status", 64'(rsp_status), 64'd2);
    checkOutput("deqe_rsp_kv", 64'(rsp_kv), 64'd0);
    checkOutput("deqe_occ", 64'(occupancy), 64'd0);

    // DEQ issued at occupancy 0: counter must not wrap
    pq_empty = 1'b0;
    pq_kvo = 32'h0001_0003;
    applyStimulus(2'b10, 32'h0, lat, pulse_lat, n_enq, n_deq, n_both, kvi_seen);
    checkOutput("deq0_pulse_count", 64'(n_deq), 64'd1);
    checkOutput("deq0_occ_sat", 64'(occupancy), 64'd0);

    // NOP
    applyStimulus(2'b00, 32'h1234_5678, lat, pulse_lat, n_enq, n_deq, n_both, kvi_seen);
    checkOutput("nop_latency", 64'(lat), 64'd2);
    checkOutput("nop_no_pulse", 64'(n_enq + n_deq), 64'd0);
    checkOutput("nop_status", 64'(rsp_status), 64'd3);
    checkOutput("nop_rsp_kv", 64'(rsp_kv), 64'd0);

    // Fill to capacity, then one more to check saturation at 15
    total_pulses = 0;
    for (int i = 0; i < 15; i++) begin
      applyStimulus(2'b01, 32'h0100 + 32'(i), lat, pulse_lat, n_enq, n_deq, n_both, kvi_seen);
      total_pulses += n_enq;
    end
    checkOutput("fill_pulses", 64'(total_pulses), 64'd15);
    checkOutput("fill_occ", 64'(occupancy), 64'd15);
    applyStimulus(2'b01, 32'h0200, lat, pulse_lat, n_enq, n_deq, n_both, kvi_seen);
    checkOutput("enq_sat_occ", 64'(occupancy), 64'd15);

    // ENQ while full: rejected
    pq_full = 1'b1;
    applyStimulus(2'b01, 32'h0300, lat, pulse_lat, n_enq, n_deq, n_both, kvi_seen);
    checkOutput("enqf_latency", 64'(lat), 64'd2);
    checkOutput("enqf_no_pulse", 64'(n_enq + n_deq), 64'd0);
    checkOutput("enqf_status", 64'(rsp_status), 64'd1);
    checkOutput("enqf_occ", 64'(occupancy), 64'd15);

    // Full and empty together: each op judged by its own flag
    pq_empty = 1'b1;
    applyStimulus(2'b10, 32'h0, lat, pulse_lat, n_enq, n_deq, n_both, kvi_seen);
    checkOutput("both_deq_status", 64'(rsp_status), 64'd2);
    checkOutput("both_deq_no_pulse", 64'(n_enq + n_deq), 64'd0);
    applyStimulus(2'b01, 32'h0400, lat, pulse_lat, n_enq, n_deq, n_both, kvi_seen);
    checkOutput("both_enq_status", 64'(rsp_status), 64'd1);
    pq_full = 1'b0;
    pq_empty = 1'b0;

    // REPL
    pq_kvo = 32'h0003_0007;
    applyStimulus(2'b11, 32'h0009_0001, lat, pulse_lat, n_enq, n_deq, n_both, kvi_seen);
    checkOutput("repl_latency", 64'(lat), 64'd3);
    checkOutput("repl_both_count", 64'(n_both), 64'd1);
    checkOutput("repl_enq_count", 64'(n_enq), 64'd1);
    checkOutput("repl_kvi", 64'(kvi_seen), 64'h0009_0001);
    checkOutput("repl_rsp_kv", 64'(rsp_kv), 64'h0003_0007);
    checkOutput("repl_status", 64'(rsp_status), 64'd0);
    checkOutput("repl_occ", 64'(occupancy), 64'd15);

    // Back-to-back ENQs; device busy for 4 cycles after the first pulse
    applyStimulus(2'b01, 32'h0000_1111, lat, pulse_lat, n_enq, n_deq, n_both, kvi_seen);
    checkOutput("b2b_first_pulse_lat", 64'(pulse_lat), 64'd2);
    pq_busy = 1'b1;
    fork
      applyStimulus(2'b01, 32'h0000_2222, lat, pulse_lat, n_enq, n_deq, n_both, kvi_seen);
      begin
        repeat (4) @(negedge clk);
        pq_busy = 1'b0;
        rsp_ready = 1'b0;
      end
    join
    checkOutput("b2b_second_pulse_lat", 64'(pulse_lat), 64'd4);
    checkOutput("b2b_second_pulse_count", 64'(n_enq), 64'd1);
    checkOutput("b2b_second_kvi", 64'(kvi_seen), 64'h0000_2222);
    checkOutput("b2b_second_latency", 64'(lat), 64'd5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("stall_enq_rsp_valid", 64'(rsp_valid), 64'd1);
      checkOutput("stall_enq_cmd_ready", 64'(cmd_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput("stall_release_rsp_valid", 64'(rsp_valid), 64'd0);

    // DEQ keys 1 then 2 (in order); first response stalled with head changing
    pq_kvo = 32'h0001_0000;
    rsp_ready = 1'b0;
    applyStimulus(2'b10, 32'h0, lat, pulse_lat, n_enq, n_deq, n_both, kvi_seen);
    pq_kvo = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("stall_deq_rsp_valid", 64'(rsp_valid), 64'd1);
      checkOutput("stall_deq_rsp_kv", 64'(rsp_kv), 64'h0001_0000);
      checkOutput("stall_deq_status", 64'(rsp_status), 64'd0);
    end
    rsp_ready = 1'b1;
    pq_kvo = 32'h0002_0000;
    applyStimulus(2'b10, 32'h0, lat, pulse_lat, n_enq, n_deq, n_both, kvi_seen);
    checkOutput("ord_ok_rsp_kv", 64'(rsp_kv), 64'h0002_0000);
    checkOutput("ord_ok_occ", 64'(occupancy), 64'd13);
    checkOutput("ord_ok_order_err", 64'(order_err), 64'd0);

    // ENQ breaks the DEQ run, then keys 2 then 1 (out of order for min-first)
    applyStimulus(2'b01, 32'h0000_0055, lat, pulse_lat, n_enq, n_deq, n_both, kvi_seen);
    checkOutput("ord_enq_occ", 64'(occupancy), 64'd14);
    pq_kvo = 32'h0002_0000;
    applyStimulus(2'b10, 32'h0, lat, pulse_lat, n_enq, n_deq, n_both, kvi_seen);
    checkOutput("ord_first_order_err", 64'(order_err), 64'd0);
    pq_kvo = 32'h0001_0000;
    applyStimulus(2'b10, 32'h0, lat, pulse_lat, n_enq, n_deq, n_both, kvi_seen);
    @(negedge clk);
    checkOutput("ord_bad_order_err", 64'(order_err), 64'(exp_order_err));
    checkOutput("ord_bad_occ", 64'(occupancy), 64'd12);
    applyStimulus(2'b00, 32'h0, lat, pulse_lat, n_enq, n_deq, n_both, kvi_seen);
    checkOutput("ord_sticky_order_err", 64'(order_err), 64'(exp_order_err));

    // Reset while the command waits in CHECK on a busy device
    pq_busy = 1'b1;
    cmd_op = 2'b01;
    cmd_kv = 32'h0000_ABCD;
    cmd_valid = 1'b1;
    for (int i = 0; i < 40 && !cmd_ready; i++) @(negedge clk);
    checkOutput("midrst_cmd_ready", 64'(cmd_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("midrst_cmd_ready_low", 64'(cmd_ready), 64'd0);
    checkOutput("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("midrst_rsp_status", 64'(rsp_status), 64'd0);
    checkOutput("midrst_occ", 64'(occupancy), 64'd0);
    checkOutput("midrst_order_err", 64'(order_err), 64'd0);
    checkOutput("midrst_pq_kvi", 64'(pq_kvi), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    pq_busy = 1'b0;
    seen_rsp = 0;
    seen_pulse = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid) seen_rsp++;
      if (pq_enq || pq_deq) seen_pulse++;
    end
    checkOutput("midrst_no_response", 64'(seen_rsp), 64'd0);
    checkOutput("midrst_no_pulse", 64'(seen_pulse), 64'd0);
    checkOutput("midrst_idle_again", 64'(cmd_ready), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
